// File: rtl/snake_pkg.sv
// Shared types and constants for the Snake game: FSM states, directions,
// plot colours and default framebuffer geometry.
package snake_pkg;

    localparam int GRID_W_DEF = 160;
    localparam int GRID_H_DEF = 120;

    typedef enum logic [2:0] {
        CLEAR      = 3'd0,
        TESTING_1  = 3'd1,
        TESTING_2  = 3'd2,
        WAIT_TICK  = 3'd3,
        STEP       = 3'd4,
        ERASE_TAIL = 3'd5,
        DRAW_HEAD  = 3'd6,
        GAME_OVER  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BORDER = 3'b111;
    localparam logic [2:0] COL_SNAKE  = 3'b010;

    // Opposite directions differ only in bit 1 (right/left, down/up).
    function automatic logic is_reverse(input dir_t cur, input dir_t req);
        return (cur ^ req) == 2'b10;
    endfunction

endpackage

// File: rtl/snake_game_hex7seg.sv
// Hex digit to active-low 7-segment decoder (bit 6 = segment g).
module hex7seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/vga_adapter.sv
// Compact stand-in for the vga_adapter core with the same plotting interface:
// a 160x120x3 framebuffer written by the plot strobe and scanned out at
// 640x480 (each framebuffer pixel covers a 4x4 block), pixel clock = clock/2.
module vga_adapter
    import snake_pkg::*;
(
    input  logic       resetn,
    input  logic       clock,
    input  logic [2:0] colour,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic       plot,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK
);

    localparam int FB_DEPTH = GRID_W_DEF * GRID_H_DEF;

    logic [2:0]  fb [FB_DEPTH];
    logic [14:0] wr_addr;
    logic [14:0] rd_addr;
    logic        pix_en_q;
    logic [9:0]  h_q;
    logic [9:0]  v_q;
    logic        visible;
    logic [2:0]  pix_q;
    logic        hs_q;
    logic        vs_q;

    assign wr_addr = 15'(y) * 15'(GRID_W_DEF) + 15'(x);
    assign rd_addr = 15'(v_q[8:2]) * 15'(GRID_W_DEF) + 15'(h_q[9:2]);
    assign visible = (h_q < 10'd640) && (v_q < 10'd480);

    // Framebuffer write port; off-screen coordinates are dropped.
    always_ff @(posedge clock) begin
        if (plot && (x < 8'(GRID_W_DEF)) && (y < 7'(GRID_H_DEF))) begin
            fb[wr_addr] <= colour;
        end
    end

    // Raster timing and scan-out at half the system clock.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            pix_q    <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                if (h_q == 10'd799) begin
                    h_q <= '0;
                    v_q <= (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
                end else begin
                    h_q <= h_q + 10'd1;
                end
                pix_q <= visible ? fb[rd_addr] : 3'b000;
                hs_q  <= ~((h_q >= 10'd656) && (h_q < 10'd752));
                vs_q  <= ~((v_q >= 10'd490) && (v_q < 10'd492));
            end
        end
    end

    assign VGA_R   = {8{pix_q[2]}};
    assign VGA_G   = {8{pix_q[1]}};
    assign VGA_B   = {8{pix_q[0]}};
    assign VGA_HS  = hs_q;
    assign VGA_VS  = vs_q;
    assign VGA_CLK = pix_en_q;

endmodule

// File: rtl/snake_game_top.sv
// Snake game top: bring-up drawing (clear, border, initial snake) followed by
// a tick-driven game loop. The plot port is a fire-and-forget strobe: when
// VGA_PLOT is high, VGA_X/VGA_Y/VGA_COLOUR describe one pixel written on that
// edge; there is no back-pressure, so every high cycle is exactly one pixel.
module snake_game_top
    import snake_pkg::*;
#(
    parameter int GRID_W      = 160,
    parameter int GRID_H      = 120,
    parameter int SNAKE_LEN   = 8,
    parameter int TICK_CYCLES = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOUR,
    output logic       VGA_PLOT
);

    localparam int IW      = (SNAKE_LEN > 1) ? $clog2(SNAKE_LEN) : 1;
    localparam int TW      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int START_X = GRID_W / 2 - SNAKE_LEN + 1;
    localparam logic [7:0]    X_LAST    = 8'(GRID_W - 1);
    localparam logic [6:0]    Y_LAST    = 7'(GRID_H - 1);
    localparam logic [6:0]    START_Y   = 7'(GRID_H / 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(SNAKE_LEN - 1);

    logic rst;
    logic unused_inputs;
    assign rst           = KEY[3];
    assign unused_inputs = ^{KEY[2:0], SW[9:2]};

    state_t        state, state_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic          side_q, side_d;     // which row/column of the border pair
    logic          phase_q, phase_d;   // border: 0 = rows, 1 = columns
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tick_q, tick_d;
    dir_t          dir_q, dir_d;
    logic [7:0]    new_x_q, new_x_d;
    logic [6:0]    new_y_q, new_y_d;
    logic [IW-1:0] head_q, head_d;
    logic [15:0]   score_q, score_d;
    logic          plot_q, plot_d;
    logic [7:0]    plot_x_q, plot_x_d;
    logic [6:0]    plot_y_q, plot_y_d;
    logic [2:0]    plot_col_q, plot_col_d;

    logic [7:0]    snake_x_q [SNAKE_LEN];
    logic [6:0]    snake_y_q [SNAKE_LEN];

    logic [IW-1:0] tail_idx;
    logic [7:0]    head_x;
    logic [6:0]    head_y;
    dir_t          step_dir;
    logic [7:0]    step_x;
    logic [6:0]    step_y;

    assign tail_idx = (head_q == IDX_LAST) ? '0 : head_q + 1'b1;
    assign head_x   = snake_x_q[head_q];
    assign head_y   = snake_y_q[head_q];

    // Next-state, counter and plot-request logic for the whole sequence.
    always_comb begin
        state_d    = state;
        x_d        = x_q;
        y_d        = y_q;
        side_d     = side_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        tick_d     = tick_q;
        dir_d      = dir_q;
        new_x_d    = new_x_q;
        new_y_d    = new_y_q;
        head_d     = head_q;
        score_d    = score_q;
        plot_d     = 1'b0;
        plot_x_d   = plot_x_q;
        plot_y_d   = plot_y_q;
        plot_col_d = plot_col_q;

        step_dir = is_reverse(dir_q, dir_t'(SW[1:0])) ? dir_q : dir_t'(SW[1:0]);
        step_x   = head_x;
        step_y   = head_y;
        case (step_dir)
            DIR_RIGHT: step_x = head_x + 8'd1;
            DIR_DOWN:  step_y = head_y + 7'd1;
            DIR_LEFT:  step_x = head_x - 8'd1;
            DIR_UP:    step_y = head_y - 7'd1;
            default:   step_x = head_x;
        endcase

        case (state)
            CLEAR: begin
                plot_d     = 1'b1;
                plot_x_d   = x_q;
                plot_y_d   = y_q;
                plot_col_d = COL_BLACK;
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = TESTING_1;
                    end else begin
                        y_d = y_q + 7'd1;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            TESTING_1: begin
                plot_d     = 1'b1;
                plot_col_d = COL_BORDER;
                if (!phase_q) begin
                    plot_x_d = x_q;
                    plot_y_d = side_q ? Y_LAST : 7'd0;
                    if (x_q == X_LAST) begin
                        x_d    = '0;
                        side_d = ~side_q;
                        if (side_q) begin
                            phase_d = 1'b1;
                            y_d     = 7'd1;
                        end
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end else begin
                    // Columns skip the corner rows already drawn.
                    plot_x_d = side_q ? X_LAST : 8'd0;
                    plot_y_d = y_q;
                    if (y_q == Y_LAST - 7'd1) begin
                        y_d    = 7'd1;
                        side_d = ~side_q;
                        if (side_q) begin
                            phase_d = 1'b0;
                            y_d     = '0;
                            state_d = TESTING_2;
                        end
                    end else begin
                        y_d = y_q + 7'd1;
                    end
                end
            end
            TESTING_2: begin
                plot_d     = 1'b1;
                plot_x_d   = snake_x_q[idx_q];
                plot_y_d   = snake_y_q[idx_q];
                plot_col_d = COL_SNAKE;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = WAIT_TICK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WAIT_TICK: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = STEP;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STEP: begin
                dir_d   = step_dir;
                new_x_d = step_x;
                new_y_d = step_y;
                if ((step_x == 8'd0) || (step_x == X_LAST) ||
                    (step_y == 7'd0) || (step_y == Y_LAST)) begin
                    state_d = GAME_OVER;
                end else begin
                    state_d = ERASE_TAIL;
                end
            end
            ERASE_TAIL: begin
                plot_d     = 1'b1;
                plot_x_d   = snake_x_q[tail_idx];
                plot_y_d   = snake_y_q[tail_idx];
                plot_col_d = COL_BLACK;
                state_d    = DRAW_HEAD;
            end
            DRAW_HEAD: begin
                plot_d     = 1'b1;
                plot_x_d   = new_x_q;
                plot_y_d   = new_y_q;
                plot_col_d = COL_SNAKE;
                head_d     = tail_idx;
                score_d    = score_q + 16'd1;
                state_d    = WAIT_TICK;
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // State, counters, score and registered plot outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state      <= CLEAR;
            x_q        <= '0;
            y_q        <= '0;
            side_q     <= 1'b0;
            phase_q    <= 1'b0;
            idx_q      <= '0;
            tick_q     <= '0;
            dir_q      <= DIR_RIGHT;
            new_x_q    <= '0;
            new_y_q    <= '0;
            head_q     <= IDX_LAST;
            score_q    <= '0;
            plot_q     <= 1'b0;
            plot_x_q   <= '0;
            plot_y_q   <= '0;
            plot_col_q <= COL_BLACK;
        end else begin
            state      <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            side_q     <= side_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            tick_q     <= tick_d;
            dir_q      <= dir_d;
            new_x_q    <= new_x_d;
            new_y_q    <= new_y_d;
            head_q     <= head_d;
            score_q    <= score_d;
            plot_q     <= plot_d;
            plot_x_q   <= plot_x_d;
            plot_y_q   <= plot_y_d;
            plot_col_q <= plot_col_d;
        end
    end

    // Circular segment buffer: new head overwrites the slot the tail vacated.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            for (int i = 0; i < SNAKE_LEN; i++) begin
                snake_x_q[i] <= 8'(START_X + i);
                snake_y_q[i] <= START_Y;
            end
        end else if (state == DRAW_HEAD) begin
            snake_x_q[tail_idx] <= new_x_q;
            snake_y_q[tail_idx] <= new_y_q;
        end
    end

    assign VGA_X      = plot_x_q;
    assign VGA_Y      = plot_y_q;
    assign VGA_COLOUR = plot_col_q;
    assign VGA_PLOT   = plot_q;
    assign LEDR       = {(state == GAME_OVER), 7'b0, dir_q};
    assign HEX4       = 7'h7F;
    assign HEX5       = 7'h7F;

    hex7seg u_hex0 (.hex_i(score_q[3:0]),   .seg_o(HEX0));
    hex7seg u_hex1 (.hex_i(score_q[7:4]),   .seg_o(HEX1));
    hex7seg u_hex2 (.hex_i(score_q[11:8]),  .seg_o(HEX2));
    hex7seg u_hex3 (.hex_i(score_q[15:12]), .seg_o(HEX3));

    vga_adapter u_vga (
        .resetn  (~rst),
        .clock   (CLOCK_50),
        .colour  (plot_col_q),
        .x       (plot_x_q),
        .y       (plot_y_q),
        .plot    (plot_q),
        .VGA_R   (VGA_R),
        .VGA_G   (VGA_G),
        .VGA_B   (VGA_B),
        .VGA_HS  (VGA_HS),
        .VGA_VS  (VGA_VS),
        .VGA_CLK (VGA_CLK)
    );

endmodule

// File: tb/tb_snake_game_top.sv
// Directed bench for snake_game_top: bring-up drawing, straight movement,
// reversal rejection, a turn, and running into the top border.
module tb_snake_game_top;
    import snake_pkg::*;

    localparam int CLEAR_PLOTS  = 160 * 120;
    localparam int BORDER_PLOTS = 2 * 160 + 2 * 118;

    logic       clk;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_CLK;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOUR;
    logic       VGA_PLOT;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Expected game-phase plots, packed {colour, x, y}.
    logic [17:0] exp_q[$];

    int plot_cnt, cx, cy, clear_ok, clear_bad, border_ok, border_bad, extra_plots;
    int snap;

    snake_game_top #(.TICK_CYCLES(16)) dut (
        .CLOCK_50(clk), .KEY(KEY), .SW(SW), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_CLK(VGA_CLK),
        .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOUR(VGA_COLOUR), .VGA_PLOT(VGA_PLOT)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Plot monitor: raster order for the clear, border membership for the
    // frame, then the expected queue for everything after.
    always @(posedge clk) begin
        #2;
        if (KEY[3]) begin
            plot_cnt = 0; cx = 0; cy = 0;
            clear_ok = 0; clear_bad = 0; border_ok = 0; border_bad = 0; extra_plots = 0;
        end else if (VGA_PLOT) begin
            if (plot_cnt < CLEAR_PLOTS) begin
                if (VGA_COLOUR == 3'b000 && int'(VGA_X) == cx && int'(VGA_Y) == cy) clear_ok++;
                else clear_bad++;
                if (cx == 159) begin cx = 0; cy++; end
                else cx++;
            end else if (plot_cnt < CLEAR_PLOTS + BORDER_PLOTS) begin
                if (VGA_COLOUR == 3'b111 &&
                    (VGA_X == 8'd0 || VGA_X == 8'd159 || VGA_Y == 7'd0 || VGA_Y == 7'd119))
                    border_ok++;
                else border_bad++;
            end else if (exp_q.size() != 0) begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("game_plot", {14'b0, VGA_COLOUR, VGA_X, VGA_Y}, {14'b0, e});
            end else begin
                extra_plots++;
            end
            plot_cnt++;
        end
    end

    // Driver tasks
    task automatic push_plot(input logic [2:0] col, input logic [7:0] x, input logic [6:0] y);
        exp_q.push_back({col, x, y});
    endtask

    task automatic push_initial_snake();
        for (int i = 0; i < 8; i++) push_plot(3'b010, 8'(73 + i), 7'd60);
    endtask

    task automatic pulse_reset();
        exp_q.delete();
        @(negedge clk);
        KEY = 4'b1000;
        @(negedge clk);
        check("rst_state", 32'(dut.state), 32'(CLEAR));
        check("rst_plot", 32'(VGA_PLOT), 32'd0);
        check("rst_xy", {17'b0, VGA_X, VGA_Y}, 32'd0);
        check("rst_colour", 32'(VGA_COLOUR), 32'd0);
        check("rst_ledr", 32'(LEDR), 32'd0);
        check("rst_hex_lo", {18'b0, HEX1, HEX0}, {18'b0, 7'h40, 7'h40});
        check("rst_hex_hi", {18'b0, HEX3, HEX2}, {18'b0, 7'h40, 7'h40});
        check("rst_hex_blank", {18'b0, HEX5, HEX4}, {18'b0, 7'h7F, 7'h7F});
        KEY = 4'b0000;
    endtask

    task automatic wait_for_state(input state_t s, input int bound, input string tag);
        int n = 0;
        while (dut.state != s && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dut.state), 32'(s));
    endtask

    task automatic wait_drain(input int bound, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_bringup();
        check("clear_raster_ok", clear_ok, CLEAR_PLOTS);
        check("clear_bad", clear_bad, 0);
        check("border_ok", border_ok, BORDER_PLOTS);
        check("border_bad", border_bad, 0);
        check("t2_hex0", 32'(HEX0), 32'h40);
    endtask

    initial begin
        KEY = 4'b1000;
        SW  = 10'd0;
        repeat (2) @(negedge clk);

        // Straight right, then a rejected reversal, then a turn down.
        SW = 10'b00;
        pulse_reset();
        push_initial_snake();
        wait_for_state(TESTING_2, 21000, "reach_testing_2");
        check_bringup();
        for (int k = 1; k <= 3; k++) begin
            push_plot(3'b000, 8'(72 + k), 7'd60);
            push_plot(3'b010, 8'(80 + k), 7'd60);
        end
        wait_drain(200, "drain_right");
        check("score_3_hex0", 32'(HEX0), 32'h30);
        check("score_3_hex1", 32'(HEX1), 32'h40);
        check("dir_right_ledr", 32'(LEDR), 32'h000);
        check("extra_right", extra_plots, 0);

        SW = 10'b10;
        for (int k = 4; k <= 5; k++) begin
            push_plot(3'b000, 8'(72 + k), 7'd60);
            push_plot(3'b010, 8'(80 + k), 7'd60);
        end
        wait_drain(200, "drain_reverse");
        check("score_5_hex0", 32'(HEX0), 32'h12);
        check("reverse_ignored_ledr", 32'(LEDR), 32'h000);

        SW = 10'b01;
        push_plot(3'b000, 8'd78, 7'd60);
        push_plot(3'b010, 8'd85, 7'd61);
        push_plot(3'b000, 8'd79, 7'd60);
        push_plot(3'b010, 8'd85, 7'd62);
        wait_drain(200, "drain_down");
        check("score_7_hex0", 32'(HEX0), 32'h78);
        check("dir_down_ledr", 32'(LEDR), 32'h001);
        check("extra_turn", extra_plots, 0);

        // Straight up from reset into the top border.
        SW = 10'b11;
        pulse_reset();
        push_initial_snake();
        wait_for_state(TESTING_2, 21000, "reach_testing_2_up");
        check_bringup();
        for (int k = 1; k <= 59; k++) begin
            if (k <= 8) push_plot(3'b000, 8'(72 + k), 7'd60);
            else        push_plot(3'b000, 8'd80, 7'(68 - k));
            push_plot(3'b010, 8'd80, 7'(60 - k));
        end
        wait_for_state(GAME_OVER, 2000, "reach_game_over");
        check("drain_up", exp_q.size(), 32'd0);
        check("extra_up", extra_plots, 0);
        check("game_over_ledr", 32'(LEDR), 32'h203);
        check("score_59_hex", {18'b0, HEX1, HEX0}, {18'b0, 7'h30, 7'h03});
        snap = plot_cnt;
        repeat (40) @(negedge clk);
        check("no_plots_after_over", plot_cnt, snap);
        check("over_plot_low", 32'(VGA_PLOT), 32'd0);
        check("over_held", 32'(dut.state), 32'(GAME_OVER));
        check("score_frozen", {18'b0, HEX1, HEX0}, {18'b0, 7'h30, 7'h03});

        pulse_reset();
        @(negedge clk);
        check("restart_state", 32'(dut.state), 32'(CLEAR));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
